// File: rtl/rvfi_trace_pkg.sv
// rtl/rvfi_trace_pkg.sv - shared constants, record types and byte-mask helpers for the commit tracer
package rvfi_trace_pkg;

    localparam int XLEN            = 32;
    localparam int NREG            = 32;
    localparam int MEMW_BITS       = 6;
    localparam int NUM_LEGAL_MASKS = 7;

    // Byte masks a well-formed RV32 access can produce: single bytes, aligned halves, full word.
    localparam logic [3:0] LEGAL_MASKS [NUM_LEGAL_MASKS] =
        '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
    } commit_rec_t;

    typedef struct packed {
        logic                 valid;
        logic [XLEN-1:0]      addr;
        logic [MEMW_BITS-1:0] width;
        logic [XLEN-1:0]      data;
    } mem_rec_t;

    // An empty mask means "no access" and is never an error.
    function automatic logic mask_is_legal(input logic [3:0] mask);
        logic ok;
        ok = (mask == 4'b0000);
        for (int i = 0; i < NUM_LEGAL_MASKS; i++) begin
            if (mask == LEGAL_MASKS[i]) begin
                ok = 1'b1;
            end
        end
        return ok;
    endfunction

    function automatic logic [XLEN-1:0] mask_bytes(input logic [3:0] mask);
        return {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
    endfunction

endpackage

// File: rtl/rvfi_commit_tracer_if.sv
// rtl/rvfi_commit_tracer_if.sv - per-retire RVFI bundle from the core into the tracer
interface rvfi_commit_tracer_if;
    import rvfi_trace_pkg::*;

    logic            rvfi_valid;
    logic [XLEN-1:0] rvfi_insn;
    logic [XLEN-1:0] rvfi_pc_rdata;
    logic [XLEN-1:0] rvfi_pc_wdata;
    logic            rvfi_trap;
    logic [4:0]      rvfi_rd_addr;
    logic [XLEN-1:0] rvfi_rd_wdata;
    logic [XLEN-1:0] rvfi_mem_addr;
    logic [3:0]      rvfi_mem_rmask;
    logic [3:0]      rvfi_mem_wmask;
    logic [XLEN-1:0] rvfi_mem_rdata;
    logic [XLEN-1:0] rvfi_mem_wdata;

    modport master (
        output rvfi_valid, rvfi_insn, rvfi_pc_rdata, rvfi_pc_wdata, rvfi_trap,
               rvfi_rd_addr, rvfi_rd_wdata, rvfi_mem_addr, rvfi_mem_rmask,
               rvfi_mem_wmask, rvfi_mem_rdata, rvfi_mem_wdata
    );

    modport slave (
        input  rvfi_valid, rvfi_insn, rvfi_pc_rdata, rvfi_pc_wdata, rvfi_trap,
               rvfi_rd_addr, rvfi_rd_wdata, rvfi_mem_addr, rvfi_mem_rmask,
               rvfi_mem_wmask, rvfi_mem_rdata, rvfi_mem_wdata
    );

endinterface

// File: rtl/rvfi_mask_decode.sv
// rtl/rvfi_mask_decode.sv - byte mask to lowest lane, access width in bits and legality
module rvfi_mask_decode
    import rvfi_trace_pkg::*;
(
    input  logic [3:0]           mask,
    output logic [1:0]           lo,
    output logic [MEMW_BITS-1:0] width,
    output logic                 legal
);

    logic [2:0] pop;

    // lowest set lane, byte count scaled to bits; malformed masks report width 0
    always_comb begin
        lo = 2'd0;
        if (mask[0]) begin
            lo = 2'd0;
        end else if (mask[1]) begin
            lo = 2'd1;
        end else if (mask[2]) begin
            lo = 2'd2;
        end else if (mask[3]) begin
            lo = 2'd3;
        end
        pop   = {2'b00, mask[0]} + {2'b00, mask[1]} + {2'b00, mask[2]} + {2'b00, mask[3]};
        legal = mask_is_legal(mask);
        width = legal ? {pop, 3'b000} : '0;
    end

endmodule

// File: rtl/rvfi_commit_tracer.sv
// rtl/rvfi_commit_tracer.sv - RVFI retire stream to commit/state/event/memory trace; TRACER_CSR_EN adds trap CSR outputs
module rvfi_commit_tracer
    import rvfi_trace_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_CAUSE = 32'd2
) (
    input  logic                 clock,
    input  logic                 reset,
    rvfi_commit_tracer_if.slave  rvfi,
    output logic                 instCommit_valid,
    output logic [XLEN-1:0]      instCommit_inst,
    output logic [XLEN-1:0]      instCommit_pc,
    output logic [NREG*XLEN-1:0] result_regs,
    output logic [XLEN-1:0]      result_pc,
    output logic                 event_valid,
    output logic [XLEN-1:0]      event_cause,
    output logic [XLEN-1:0]      event_exceptionPC,
    output logic [XLEN-1:0]      event_exceptionInst,
    output logic                 mem_read_valid,
    output logic [XLEN-1:0]      mem_read_addr,
    output logic [MEMW_BITS-1:0] mem_read_memWidth,
    output logic [XLEN-1:0]      mem_read_data,
    output logic                 mem_write_valid,
    output logic [XLEN-1:0]      mem_write_addr,
    output logic [MEMW_BITS-1:0] mem_write_memWidth,
    output logic [XLEN-1:0]      mem_write_data,
    output logic                 protocol_err
`ifdef TRACER_CSR_EN
    ,
    output logic [XLEN-1:0]      result_csr_mepc,
    output logic [XLEN-1:0]      result_csr_mcause,
    output logic [XLEN-1:0]      result_csr_mtval
`endif
);

    logic [1:0]           rd_lo, wr_lo;
    logic [MEMW_BITS-1:0] rd_width, wr_width;
    logic                 rd_legal, wr_legal;
    logic                 trap_now;
    logic                 retire_err;
    mem_rec_t             rd_next, wr_next;

    commit_rec_t                   commit_q;
    mem_rec_t                      rd_q, wr_q;
    logic                          ev_valid_q;
    logic [XLEN-1:0]               ev_cause_q, ev_pc_q, ev_inst_q;
    logic [NREG-1:0][XLEN-1:0]     shadow_regs;
    logic [XLEN-1:0]               pc_q;
    logic                          err_q;

    rvfi_mask_decode u_rd_decode (
        .mask  (rvfi.rvfi_mem_rmask),
        .lo    (rd_lo),
        .width (rd_width),
        .legal (rd_legal)
    );

    rvfi_mask_decode u_wr_decode (
        .mask  (rvfi.rvfi_mem_wmask),
        .lo    (wr_lo),
        .width (wr_width),
        .legal (wr_legal)
    );

    // next memory records: a trapped instruction never reports an access
    always_comb begin
        trap_now      = rvfi.rvfi_valid & rvfi.rvfi_trap;
        retire_err    = rvfi.rvfi_valid &
                        ((rvfi.rvfi_pc_rdata[1:0] != 2'b00) | !rd_legal | !wr_legal);
        rd_next.valid = rvfi.rvfi_valid & !rvfi.rvfi_trap & (rvfi.rvfi_mem_rmask != 4'b0000);
        rd_next.addr  = rvfi.rvfi_mem_addr + {30'd0, rd_lo};
        rd_next.width = rd_width;
        rd_next.data  = (rvfi.rvfi_mem_rdata & mask_bytes(rvfi.rvfi_mem_rmask)) >> {rd_lo, 3'b000};
        wr_next.valid = rvfi.rvfi_valid & !rvfi.rvfi_trap & (rvfi.rvfi_mem_wmask != 4'b0000);
        wr_next.addr  = rvfi.rvfi_mem_addr + {30'd0, wr_lo};
        wr_next.width = wr_width;
        wr_next.data  = (rvfi.rvfi_mem_wdata & mask_bytes(rvfi.rvfi_mem_wmask)) >> {wr_lo, 3'b000};
    end

    // one-cycle retire capture: valids pulse, payloads and shadow state hold between retires
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            commit_q    <= '0;
            rd_q        <= '0;
            wr_q        <= '0;
            ev_valid_q  <= 1'b0;
            ev_cause_q  <= '0;
            ev_pc_q     <= '0;
            ev_inst_q   <= '0;
            shadow_regs <= '0;
            pc_q        <= RESET_PC;
            err_q       <= 1'b0;
        end else begin
            commit_q.valid <= rvfi.rvfi_valid;
            ev_valid_q     <= trap_now;
            rd_q.valid     <= rd_next.valid;
            wr_q.valid     <= wr_next.valid;
            err_q          <= err_q | retire_err;
            if (rvfi.rvfi_valid) begin
                commit_q.inst <= rvfi.rvfi_insn;
                commit_q.pc   <= rvfi.rvfi_pc_rdata;
                pc_q          <= rvfi.rvfi_pc_wdata;
                if (!rvfi.rvfi_trap && rvfi.rvfi_rd_addr != 5'd0) begin
                    shadow_regs[rvfi.rvfi_rd_addr] <= rvfi.rvfi_rd_wdata;
                end
            end
            if (trap_now) begin
                ev_cause_q <= TRAP_CAUSE;
                ev_pc_q    <= rvfi.rvfi_pc_rdata;
                ev_inst_q  <= rvfi.rvfi_insn;
            end
            if (rd_next.valid) begin
                rd_q <= rd_next;
            end
            if (wr_next.valid) begin
                wr_q <= wr_next;
            end
        end
    end

`ifdef TRACER_CSR_EN
    // trap CSRs land in the same cycle as event_valid
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            result_csr_mepc   <= '0;
            result_csr_mcause <= '0;
            result_csr_mtval  <= '0;
        end else if (trap_now) begin
            result_csr_mepc   <= rvfi.rvfi_pc_rdata;
            result_csr_mcause <= TRAP_CAUSE;
            result_csr_mtval  <= rvfi.rvfi_insn;
        end
    end
`endif

    assign instCommit_valid    = commit_q.valid;
    assign instCommit_inst     = commit_q.inst;
    assign instCommit_pc       = commit_q.pc;
    assign result_regs         = shadow_regs;
    assign result_pc           = pc_q;
    assign event_valid         = ev_valid_q;
    assign event_cause         = ev_cause_q;
    assign event_exceptionPC   = ev_pc_q;
    assign event_exceptionInst = ev_inst_q;
    assign mem_read_valid      = rd_q.valid;
    assign mem_read_addr       = rd_q.addr;
    assign mem_read_memWidth   = rd_q.width;
    assign mem_read_data       = rd_q.data;
    assign mem_write_valid     = wr_q.valid;
    assign mem_write_addr      = wr_q.addr;
    assign mem_write_memWidth  = wr_q.width;
    assign mem_write_data      = wr_q.data;
    assign protocol_err        = err_q;

endmodule
